// File: rtl/jt10_adpcm_fetch.sv
// ADPCM-A ROM fetch stage: per-channel one-byte cache with a round-robin SDRAM request engine.
// Optional WAIT timeout enabled by defining JT10_ADPCM_FETCH_TOUT_EN.
module jt10_adpcm_fetch #(
    parameter int unsigned TOUT = 64
) (
    input  logic        rst_n,
    input  logic        clk,
    input  logic        cen,
    input  logic [5:0]  cur_ch,
    input  logic [19:0] addr,
    input  logic [4:0]  bank,
    input  logic        sel,
    input  logic        roe_n,
    input  logic        clr,
    output logic [24:0] rom_addr,
    output logic        rom_cs,
    input  logic        rom_ok,
    input  logic [7:0]  rom_data,
    output logic [3:0]  nibble,
    output logic        nibble_ok,
    output logic [5:0]  underrun,
    input  logic [5:0]  clr_underrun
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e      st_q, st_d;
    logic [2:0]  ch_q, ch_d, ptr_q, ptr_d;
    logic [24:0] rom_addr_q, rom_addr_d;
    logic        cs_q, cs_d, armed_q, armed_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [3:0]  nibble_q, nibble_d;
    logic        nibble_ok_q, nibble_ok_d;
    logic [5:0]  underrun_q, underrun_d, ur_set;
    logic [7:0]  data_q [6];
    logic [7:0]  data_d [6];
    logic [24:0] tag_q [6];
    logic [24:0] tag_d [6];
    logic [24:0] preq_q [6];
    logic [24:0] preq_d [6];
    logic [5:0]  valid_q, valid_d, pending_q, pending_d;

    logic [24:0] a_cur, a_inc;
    logic [2:0]  k, pick;
    logic        found;
    logic [3:0]  rr_sum;
    logic        timeout;

    assign a_cur = {bank, addr};
    assign a_inc = {bank, addr + 20'd1};

    function automatic logic [2:0] next_ch(input logic [2:0] c);
        return (c == 3'd5) ? 3'd0 : c + 3'd1;
    endfunction

    always_comb begin
        k = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (cur_ch[i]) k = 3'(i);
        end
    end

    // Walk offsets from the far end so the channel nearest the pointer wins.
    always_comb begin
        pick   = ptr_q;
        found  = 1'b0;
        rr_sum = 4'd0;
        for (int i = 5; i >= 0; i--) begin
            rr_sum = {1'b0, ptr_q} + 4'(i);
            if (rr_sum >= 4'd6) rr_sum = rr_sum - 4'd6;
            if (pending_q[rr_sum[2:0]]) begin
                pick  = rr_sum[2:0];
                found = 1'b1;
            end
        end
    end

`ifdef JT10_ADPCM_FETCH_TOUT_EN
    localparam int unsigned CntW = $clog2(TOUT + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = (st_q == StWait) ? cnt_q + 1'b1 : '0;
        timeout = (st_q == StWait) && (cnt_q == CntW'(TOUT - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        st_d        = st_q;
        ch_d        = ch_q;
        ptr_d       = ptr_q;
        rom_addr_d  = rom_addr_q;
        cs_d        = cs_q;
        armed_d     = armed_q;
        rdata_d     = rdata_q;
        nibble_d    = nibble_q;
        nibble_ok_d = nibble_ok_q;
        data_d      = data_q;
        tag_d       = tag_q;
        preq_d      = preq_q;
        valid_d     = valid_q;
        pending_d   = pending_q;
        ur_set      = '0;

        case (st_q)
            StIdle: begin
                if (found) begin
                    ch_d       = pick;
                    rom_addr_d = preq_q[pick];
                    cs_d       = 1'b1;
                    armed_d    = 1'b0;
                    st_d       = StWait;
                end
            end
            StWait: begin
                // rom_ok is ignored on the first WAIT cycle; it may be left over from the last request.
                armed_d = 1'b1;
                if (armed_q && rom_ok) begin
                    rdata_d = rom_data;
                    cs_d    = 1'b0;
                    st_d    = StDone;
                end else if (timeout) begin
                    cs_d            = 1'b0;
                    pending_d[ch_q] = 1'b0;
                    ur_set[ch_q]    = 1'b1;
                    ptr_d           = next_ch(ch_q);
                    st_d            = StIdle;
                end
            end
            StDone: begin
                if (preq_q[ch_q] == rom_addr_q) begin
                    data_d[ch_q]    = rdata_q;
                    tag_d[ch_q]     = rom_addr_q;
                    valid_d[ch_q]   = 1'b1;
                    pending_d[ch_q] = 1'b0;
                end
                ptr_d = next_ch(ch_q);
                st_d  = StIdle;
            end
            default: st_d = StIdle;
        endcase

        // Slot handling follows the FSM so a same-cycle post or clr overrides a cache fill.
        if (cen) begin
            nibble_ok_d = 1'b0;
            if ($onehot(cur_ch)) begin
                if (clr) begin
                    valid_d[k]   = 1'b0;
                    preq_d[k]    = a_cur;
                    pending_d[k] = 1'b1;
                    nibble_d     = 4'd0;
                end else if (!roe_n) begin
                    if (valid_q[k] && (tag_q[k] == a_cur)) begin
                        nibble_d    = sel ? data_q[k][3:0] : data_q[k][7:4];
                        nibble_ok_d = 1'b1;
                        if (sel) begin
                            preq_d[k]    = a_inc;
                            pending_d[k] = 1'b1;
                        end
                    end else begin
                        nibble_d     = 4'd0;
                        ur_set[k]    = 1'b1;
                        preq_d[k]    = a_cur;
                        pending_d[k] = 1'b1;
                    end
                end
            end
        end

        underrun_d = (underrun_q | ur_set) & ~clr_underrun;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= StIdle;
            ch_q        <= 3'd0;
            ptr_q       <= 3'd0;
            rom_addr_q  <= '0;
            cs_q        <= 1'b0;
            armed_q     <= 1'b0;
            rdata_q     <= '0;
            nibble_q    <= '0;
            nibble_ok_q <= 1'b0;
            underrun_q  <= '0;
            valid_q     <= '0;
            pending_q   <= '0;
            for (int i = 0; i < 6; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
                preq_q[i] <= '0;
            end
        end else begin
            st_q        <= st_d;
            ch_q        <= ch_d;
            ptr_q       <= ptr_d;
            rom_addr_q  <= rom_addr_d;
            cs_q        <= cs_d;
            armed_q     <= armed_d;
            rdata_q     <= rdata_d;
            nibble_q    <= nibble_d;
            nibble_ok_q <= nibble_ok_d;
            underrun_q  <= underrun_d;
            valid_q     <= valid_d;
            pending_q   <= pending_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
            preq_q      <= preq_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rom_cs    = cs_q;
    assign nibble    = nibble_q;
    assign nibble_ok = nibble_ok_q;
    assign underrun  = underrun_q;

endmodule

// File: doc/jt10_adpcm_fetch.md
Name: jt10_adpcm_fetch

Overview:
ROM fetch and nibble-delivery stage for the six ADPCM-A channels. It sits directly downstream of the ADPCM-A address counter and upstream of the ADPCM-A nibble decoder. It turns the counter's per-slot byte address and nibble select into a 4-bit sample, using a one-byte cache per channel. A round-robin request engine fetches and prefetches bytes from the SDRAM ROM port through a cs/ok handshake.

Parameters:
TOUT, 64, WAIT-state clock cycles before timeout (used only with the optional feature).

Ports:
rst_n  in  1  async reset, active low
clk  in  1  system clock; the only clock
cen  in  1  666 kHz pipeline enable
cur_ch  in  6  one-hot current channel slot, aligned with counter outputs
addr  in  20  byte address from counter
bank  in  5  bank from counter
sel  in  1  nibble select: 0 = high nibble, 1 = low nibble
roe_n  in  1  low = slot consumes a nibble this cen
clr  in  1  slot restarted; invalidate its cache
rom_addr  out  25  {bank,addr} of outstanding request
rom_cs  out  1  request strobe
rom_ok  in  1  ROM data valid
rom_data  in  8  ROM byte
nibble  out  4  delivered sample nibble
nibble_ok  out  1  nibble valid this slot
underrun  out  6  sticky per-channel miss flags
clr_underrun  in  6  per-bit clear; clear wins over a same-cycle set

Behaviour:
- Reset values: nibble=0, nibble_ok=0, rom_cs=0, rom_addr=0, underrun=0. Per channel: valid=0, pending=0. FSM=IDLE. Round-robin pointer=ch0.
- Per-channel state: byte[7:0], tag[24:0], valid, pending, preq[24:0].
- Slot processing happens on a clk edge with cen=1, for slot k = set bit of cur_ch. If cur_ch is not one-hot, the slot is ignored and nibble_ok=0.
- A={bank,addr}. A+1 increments the low 20 bits modulo 2^20; bank is unchanged.
- clr=1: valid[k]=0; post request A; nibble=0, nibble_ok=0; no underrun set. clr takes priority over roe_n.
- roe_n=0, hit (valid[k] and tag[k]==A): nibble=sel ? byte[3:0] : byte[7:4]; nibble_ok=1. If sel=1, post prefetch A+1.
- roe_n=0, miss: nibble=0; nibble_ok=0; underrun[k] set; post request A.
- roe_n=1: nibble_ok=0; nibble holds its value.
- nibble and nibble_ok are registered on the cen edge and held until the next cen edge (latency 1 cen).
- Post request: preq[k]=address; pending[k]=1. A newer post overwrites an older one, including one posted during WAIT.
- FSM runs on every clk, independent of cen:
  - IDLE: if any pending bit is set, select the first pending channel at or after the pointer, wrapping 5->0; latch rom_addr=preq; rom_cs=1; go to WAIT.
  - WAIT: rom_addr is stable. When rom_ok=1, on a cycle at least one clk after entry, capture rom_data; rom_cs=0; go to DONE.
  - DONE: if preq[ch] still equals rom_addr, write byte/tag, set valid, clear pending. Otherwise discard the data and keep pending. Pointer=ch+1. Go to IDLE.
- A cache write and a slot lookup in the same clk for the same channel: lookup uses the pre-write contents.
- Reset asserted mid-transaction: immediate return to reset values. rom_cs drops asynchronously.
- Throughput: each channel is visited every 6 cen, so a byte fetched within 6 cen of the low-nibble slot hits.

Optional Feature:
JT10_ADPCM_FETCH_TOUT_EN:
- Defined: a counter runs in WAIT. After TOUT clk without rom_ok, rom_cs=0, the request is dropped (pending cleared), underrun[ch] is set, and the FSM returns to IDLE.
- Undefined: WAIT lasts indefinitely; no counter logic is synthesised.

Test Plan:
1. Reset, then clr on ch0 with A=0x00100. ROM returns 0xA7 after 3 clk. Slot ch0 roe_n=0 sel=0 -> nibble=0xA, nibble_ok=1; next ch0 visit sel=1 -> nibble=0x7, rom_addr=0x00101 requested.
2. Lookup with no valid data (ch3 roe_n=0, A=0x12345, no prior fetch) -> nibble_ok=0, underrun=6'b001000; clr_underrun[3] pulse -> underrun=0.
3. Pending on ch1, ch2 and ch4 simultaneously, pointer=ch2 -> ROM requests in order ch2, ch4, ch1.
4. Prefetch at addr=0xFFFFF, bank=3 -> rom_addr={5'd3,20'h00000}.
5. During WAIT for ch0 at 0x00200, clr on ch0 with 0x00300 -> returned byte discarded, next request 0x00300, valid[0] stays 0 until then.
6. With JT10_ADPCM_FETCH_TOUT_EN, hold rom_ok=0 -> rom_cs falls after 64 clk, underrun[ch] set, FSM serves the next pending channel.
